evt_stream_collector: RTL

Parametrised N-channel event collector for the engine output path. It buffers per-datapath-group spike/time event streams and merges them into one output stream with rotating-priority arbitration. An optional barrier mode holds each channel at its next time (barrier) event until every enabled channel has reached one, then emits a single merged barrier. It generalises the fixed 16-channel synchroniser-plus-arbiter chain with configurable channel count, width, depth, enable mask and run-time mode.

---
 rtl/evt_stream_collector.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/evt_stream_collector.sv
// N-channel event collector: per-channel FIFOs merged into one stream by rotating-priority
// arbitration, with an optional barrier mode that fuses one barrier from every enabled channel.
module evt_stream_collector #(
    parameter int          N_CH       = 16,
    parameter int          DATA_WIDTH = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [3:0]  BARRIER_OP = 4'h1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       mode_i,
    input  logic [N_CH-1:0]            ch_en_i,
    input  logic [N_CH-1:0]            in_valid_i,
    output logic [N_CH-1:0]            in_ready_o,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_WIDTH-1:0]      out_data_o,
    output logic [N_CH-1:0]            ch_full_o,
    output logic [15:0]                barrier_cnt_o,
    output logic                       busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {ST_RUN, ST_EMIT} state_t;

    logic [DATA_WIDTH-1:0] mem_q    [N_CH][FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q [N_CH];
    logic [AW:0]           rd_ptr_q [N_CH];
    logic [DATA_WIDTH-1:0] head     [N_CH];

    logic [N_CH-1:0] full, empty, is_bar, push, pop, eligible, parked;
    logic            all_parked, can_load;

    state_t                state_q, state_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [15:0]           bcnt_q, bcnt_d;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  grant_found;
    logic [PW-1:0]         grant_idx, low_idx;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign full[k]       = (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]) &&
                               (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]);
        assign empty[k]      = (wr_ptr_q[k] == rd_ptr_q[k]);
        assign head[k]       = mem_q[k][rd_ptr_q[k][AW-1:0]];
        assign is_bar[k]     = (head[k][DATA_WIDTH-1 -: 4] == BARRIER_OP);
        assign in_ready_o[k] = ch_en_i[k] ? !full[k] : 1'b1;
        assign push[k]       = ch_en_i[k] && in_valid_i[k] && !full[k];
        assign eligible[k]   = ch_en_i[k] && !empty[k] && (!mode_i || !is_bar[k]);
        assign parked[k]     = mode_i && ch_en_i[k] && !empty[k] && is_bar[k];
    end

    // Disabled channels count as parked so they never hold up a merged barrier.
    assign all_parked = mode_i && (|ch_en_i) && (&(parked | ~ch_en_i));
    assign can_load   = !out_valid_q || out_ready_i;

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < N_CH; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k][AW-1:0]] <= in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A disabled channel is flushed by snapping its read pointer onto its write pointer.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < N_CH; k++) begin
            if (rst_i) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end else if (!ch_en_i[k]) begin
                rd_ptr_q[k] <= wr_ptr_q[k];
            end else begin
                if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + (AW+1)'(1);
                if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + (AW+1)'(1);
            end
        end
    end

    always_comb begin : arb_search
        int            idx;
        logic [PW-1:0] cand;
        idx         = 0;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        low_idx     = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            cand = PW'(idx);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_en_i[i]) low_idx = PW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        bcnt_d    = bcnt_q;
        pop       = '0;
        load      = 1'b0;
        load_data = '0;
        case (state_q)
            ST_RUN: begin
                if (all_parked) begin
                    state_d = ST_EMIT;
                end else if (can_load && grant_found) begin
                    load           = 1'b1;
                    load_data      = head[grant_idx];
                    pop[grant_idx] = 1'b1;
                    rr_ptr_d       = (grant_idx == PW'(N_CH - 1)) ? '0 : grant_idx + PW'(1);
                end
            end
            ST_EMIT: begin
                // Losing the all-parked condition (mode drop, channel changes) aborts the merge.
                if (!all_parked) begin
                    state_d = ST_RUN;
                end else if (can_load) begin
                    load      = 1'b1;
                    load_data = head[low_idx];
                    pop       = ch_en_i;
                    bcnt_d    = bcnt_q + 16'd1;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            rr_ptr_q    <= '0;
            bcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            bcnt_q   <= bcnt_d;
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= load_data;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign ch_full_o     = full;
    assign barrier_cnt_o = bcnt_q;
    assign busy_o        = (|(~empty)) || out_valid_q;

endmodule
